// File: rtl/encoder4x2_pending.sv
// rtl/encoder4x2_pending.sv - registered 4-to-2 priority encoder with sticky pending requests
// Requests are buffered in pend; the highest-priority one is presented with valid/ready.
module encoder4x2_pending #(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       ready,
    input  logic       clr_ovf,
    output logic       s1,
    output logic       s0,
    output logic       valid,
    output logic [3:0] pend,
    output logic       ovf
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [3:0] req;
    logic [3:0] acc;
    logic [3:0] rem;
    logic [1:0] code;
    logic [1:0] sel;

    assign req  = {i3, i2, i1, i0};
    assign code = {s1, s0};
    assign rem  = pend & ~acc;

    always_comb begin
        acc = 4'b0000;
        if (valid && ready)
            acc[code] = 1'b1;
    end

    // New arrivals are excluded: selection sees only what was already pending.
    always_comb begin
        sel = 2'd0;
        if (PRIO_MSB) begin
            if (rem[3])      sel = 2'd3;
            else if (rem[2]) sel = 2'd2;
            else if (rem[1]) sel = 2'd1;
            else             sel = 2'd0;
        end else begin
            if (rem[0])      sel = 2'd0;
            else if (rem[1]) sel = 2'd1;
            else if (rem[2]) sel = 2'd2;
            else if (rem[3]) sel = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 4'b0000;
            s1    <= 1'b0;
            s0    <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            pend <= rem | req;

            // A request landing on a still-pending, unaccepted bit is lost.
            if (|(req & pend & ~acc))
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend != 4'b0000) begin
                        {s1, s0} <= sel;
                        valid    <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        if (rem != 4'b0000) begin
                            {s1, s0} <= sel;
                        end else begin
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder4x2_pending.sv
// tb/tb_encoder4x2_pending.sv - scoreboard bench for encoder4x2_pending
// Two instances share request lines: PRIO_MSB=1 (a) and PRIO_MSB=0 (b).
module tb_encoder4x2_pending;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i0 = 1'b0, i1 = 1'b0, i2 = 1'b0, i3 = 1'b0;
    logic       ready_a = 1'b0, ready_b = 1'b0, clr_ovf = 1'b0;
    logic       a_s1, a_s0, a_valid, a_ovf;
    logic       b_s1, b_s0, b_valid, b_ovf;
    logic [3:0] a_pend, b_pend;

    int total = 0;
    int bad   = 0;
    int qa[$];
    int qb[$];

    always #5 clk = ~clk;

    encoder4x2_pending #(.PRIO_MSB(1'b1)) u_msb (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .ready(ready_a), .clr_ovf(clr_ovf),
        .s1(a_s1), .s0(a_s0), .valid(a_valid), .pend(a_pend), .ovf(a_ovf)
    );

    encoder4x2_pending #(.PRIO_MSB(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .ready(ready_b), .clr_ovf(clr_ovf),
        .s1(b_s1), .s0(b_s0), .valid(b_valid), .pend(b_pend), .ovf(b_ovf)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each accepted code is compared with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && a_valid && ready_a) begin
            if (qa.size() == 0) check("a_unexpected_code", {a_s1, a_s0}, -1);
            else check("a_code", {a_s1, a_s0}, qa.pop_front());
        end
        if (!rst && b_valid && ready_b) begin
            if (qb.size() == 0) check("b_unexpected_code", {b_s1, b_s0}, -1);
            else check("b_code", {b_s1, b_s0}, qb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        check("rst_valid", a_valid, 0);
        check("rst_pend", a_pend, 0);
        check("rst_code", {a_s1, a_s0}, 0);
        check("rst_ovf", a_ovf, 0);
        rst = 1'b0;
        step();

        // single pulse on i2, 2-cycle latency
        ready_a = 1'b1;
        i2 = 1'b1; qa.push_back(2);
        step();
        i2 = 1'b0;
        check("t1_pend", a_pend, 4'b0100);
        check("t1_valid0", a_valid, 0);
        step();
        check("t1_valid1", a_valid, 1);
        check("t1_code", {a_s1, a_s0}, 2);
        step();
        check("t1_valid_end", a_valid, 0);
        check("t1_pend_end", a_pend, 0);

        // three requests drained back to back
        i0 = 1'b1; i1 = 1'b1; i3 = 1'b1;
        qa.push_back(3); qa.push_back(1); qa.push_back(0);
        step();
        {i0, i1, i3} = 3'b000;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_valid", a_valid, 1);
        end
        step();
        check("t2_valid_end", a_valid, 0);
        check("t2_pend_end", a_pend, 0);
        check("t2_q_empty", qa.size(), 0);

        // stall with i1 presented, i3 arrives meanwhile
        ready_a = 1'b0;
        i1 = 1'b1; qa.push_back(1);
        step();
        i1 = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin i3 = 1'b1; qa.push_back(3); end
            step();
            i3 = 1'b0;
            check("t3_stall_valid", a_valid, 1);
            check("t3_stall_code", {a_s1, a_s0}, 1);
        end
        ready_a = 1'b1;
        step();
        check("t3_next_code", {a_s1, a_s0}, 3);
        step();
        check("t3_valid_end", a_valid, 0);
        check("t3_ovf", a_ovf, 0);
        check("t3_q_empty", qa.size(), 0);

        // overflow, clear, and re-request on acceptance
        ready_a = 1'b0;
        i2 = 1'b1; qa.push_back(2);
        step();
        i2 = 1'b0;
        step();
        check("t4_presented", {a_s1, a_s0}, 2);
        i2 = 1'b1;
        step();
        i2 = 1'b0;
        check("t4_ovf_set", a_ovf, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4_ovf_clr", a_ovf, 0);
        i2 = 1'b1; ready_a = 1'b1; qa.push_back(2);
        step();
        i2 = 1'b0;
        check("t4_ovf_accept", a_ovf, 0);
        check("t4_pend_re", a_pend, 4'b0100);
        check("t4_valid_gap", a_valid, 0);
        step();
        check("t4_reissue_valid", a_valid, 1);
        check("t4_reissue_code", {a_s1, a_s0}, 2);
        step();
        check("t4_valid_end", a_valid, 0);
        check("t4_q_empty", qa.size(), 0);

        // asynchronous reset while holding a code with ovf set
        ready_a = 1'b0;
        i3 = 1'b1;
        step();
        i3 = 1'b0;
        step();
        i3 = 1'b1;
        step();
        i3 = 1'b0;
        check("t5_pre_valid", a_valid, 1);
        check("t5_pre_ovf", a_ovf, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_valid", a_valid, 0);
        check("t5_code", {a_s1, a_s0}, 0);
        check("t5_pend", a_pend, 0);
        check("t5_ovf", a_ovf, 0);
        step();
        rst = 1'b0;
        step();

        // low-index priority instance
        ready_b = 1'b1;
        i0 = 1'b1; i3 = 1'b1;
        qb.push_back(0); qb.push_back(3);
        step();
        {i0, i3} = 2'b00;
        step();
        check("t6_first", {b_s1, b_s0}, 0);
        step();
        check("t6_second", {b_s1, b_s0}, 3);
        step();
        check("t6_valid_end", b_valid, 0);
        check("t6_pend_end", b_pend, 0);
        check("t6_q_empty", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
